// File: rtl/instr_mem_responder.sv
// Instruction memory answering one fetch at a time after a fixed access latency.
// Misaligned or out-of-range fetches return a flagged NOP; a side port loads the program.
module instr_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic [31:0] resp_addr,
  output logic        resp_err,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_wdata
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [31:0]   addr_q;
  logic          resp_valid_q;
  logic [31:0]   resp_instr_q;
  logic [31:0]   resp_addr_q;
  logic          resp_err_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          fetch_err;
  logic [AW-1:0] fetch_idx;
  logic          prog_hit;
  logic          unused_prog_bits;

  assign fetch_err        = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_W);
  assign fetch_idx        = addr_q[AW+1:2];
  assign prog_hit         = prog_addr[31:2] < DEPTH_W;
  assign unused_prog_bits = ^prog_addr[1:0];

  // Memory is never reset so a loaded program survives a reset pulse.
  always_ff @(posedge clk) begin
    if (prog_we && prog_hit) begin
      mem[prog_addr[AW+1:2]] <= prog_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_instr_q <= '0;
      resp_addr_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            cnt_q   <= CNT_INIT;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            // Non-blocking read here sees the pre-write word on a same-edge load.
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_addr_q  <= addr_q;
            resp_err_q   <= fetch_err;
            resp_instr_q <= fetch_err ? NOP : mem[fetch_idx];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) && rst;
  assign resp_valid = resp_valid_q;
  assign resp_instr = resp_instr_q;
  assign resp_addr  = resp_addr_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench: three responders (LATENCY 2, 1, 15) on a shared program bus,
// directed and random fetches checked against a word-array reference model.
module tb_instr_mem_responder;

  localparam int N     = 3;
  localparam int DEPTH = 256;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid  [N];
  logic        req_ready  [N];
  logic [31:0] req_addr   [N];
  logic        resp_valid [N];
  logic        resp_ready [N];
  logic [31:0] resp_instr [N];
  logic [31:0] resp_addr  [N];
  logic        resp_err   [N];
  logic        prog_we    = 1'b0;
  logic [31:0] prog_addr  = '0;
  logic [31:0] prog_wdata = '0;

  logic [31:0] model [DEPTH];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    instr_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(lat_of(gi))) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[gi]), .req_ready(req_ready[gi]), .req_addr(req_addr[gi]),
      .resp_valid(resp_valid[gi]), .resp_ready(resp_ready[gi]),
      .resp_instr(resp_instr[gi]), .resp_addr(resp_addr[gi]), .resp_err(resp_err[gi]),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
    );
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d: got %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    if ((a >> 2) < DEPTH) model[a[9:2]] = d;
  endtask

  task automatic exp_of(input logic [31:0] a, output logic [31:0] ei, output logic ee);
    if (a[1:0] != 2'b00 || (a >> 2) >= DEPTH) begin
      ee = 1'b1;
      ei = 32'h0000_0013;
    end else begin
      ee = 1'b0;
      ei = model[a[9:2]];
    end
  endtask

  task automatic prog_write(input logic [31:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    tick();
    prog_we = 1'b0;
    model_write(a, d);
  endtask

  // One fetch; hold > 0 keeps resp_ready low for that many extra cycles.
  task automatic fetch(input int k, input logic [31:0] a, input int hold);
    logic [31:0] ei;
    logic        ee;
    int          n;
    exp_of(a, ei, ee);
    chk("req_ready_idle", k, 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1; req_addr[k] = a; resp_ready[k] = (hold == 0);
    tick();
    req_valid[k] = 1'b0; req_addr[k] = $urandom;
    n = 0;
    while (resp_valid[k] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("latency", k, n, lat_of(k));
    chk("instr", k, resp_instr[k], ei);
    chk("addr", k, resp_addr[k], a);
    chk("err", k, 32'(resp_err[k]), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      req_valid[k] = 1'b1; req_addr[k] = $urandom & 32'h0000_03FC;
      if ($urandom_range(0, 1) == 1) begin
        prog_we = 1'b1; prog_addr = a; prog_wdata = $urandom;
      end
      tick();
      if (prog_we) begin
        model_write(prog_addr, prog_wdata);
        prog_we = 1'b0;
      end
      chk("hold_valid", k, 32'(resp_valid[k]), 32'd1);
      chk("hold_instr", k, resp_instr[k], ei);
      chk("hold_addr", k, resp_addr[k], a);
      chk("hold_err", k, 32'(resp_err[k]), 32'(ee));
      chk("hold_req_ready", k, 32'(req_ready[k]), 32'd0);
    end
    req_valid[k] = 1'b0; resp_ready[k] = 1'b1;
    tick();
    chk("done_valid", k, 32'(resp_valid[k]), 32'd0);
    chk("done_req_ready", k, 32'(req_ready[k]), 32'd1);
    resp_ready[k] = 1'b0;
    $display("fetch dut%0d lat=%0d addr=%h instr=%h err=%0d hold=%0d", k, n, a, ei, ee, hold);
  endtask

  // Program write lands on the same edge the response is registered.
  task automatic collide(input int k, input logic [31:0] a, input logic [31:0] oldv, input logic [31:0] newv);
    prog_write(a, oldv);
    req_valid[k] = 1'b1; req_addr[k] = a; resp_ready[k] = 1'b0;
    tick();
    req_valid[k] = 1'b0;
    for (int i = 0; i < lat_of(k) - 1; i++) tick();
    prog_we = 1'b1; prog_addr = a; prog_wdata = newv;
    tick();
    prog_we = 1'b0;
    model_write(a, newv);
    chk("collide_valid", k, 32'(resp_valid[k]), 32'd1);
    chk("collide_instr", k, resp_instr[k], oldv);
    resp_ready[k] = 1'b1;
    tick();
    resp_ready[k] = 1'b0;
    chk("collide_req_ready", k, 32'(req_ready[k]), 32'd1);
    $display("collide dut%0d addr=%h old=%h new=%h", k, a, oldv, newv);
    fetch(k, a, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = '0; resp_ready[k] = 1'b0;
    end
    tick();
    tick();
    for (int k = 0; k < N; k++) begin
      chk("rst_valid", k, 32'(resp_valid[k]), 32'd0);
      chk("rst_instr", k, resp_instr[k], 32'd0);
      chk("rst_addr", k, resp_addr[k], 32'd0);
      chk("rst_err", k, 32'(resp_err[k]), 32'd0);
      chk("rst_req_ready", k, 32'(req_ready[k]), 32'd0);
    end
    rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) chk("release_req_ready", k, 32'(req_ready[k]), 32'd1);

    for (int w = 0; w < DEPTH; w++) prog_write(32'(w * 4), $urandom);
    prog_write(32'h0, 32'h0050_0093);
    prog_write(32'h4, 32'h00A0_0113);
    prog_write(32'h8, 32'h0020_81B3);
    prog_write(32'hC, 32'h0000_006F);

    for (int k = 0; k < N; k++)
      for (int i = 0; i < 4; i++) fetch(k, 32'(i * 4), 0);

    fetch(0, 32'h10, 5);

    for (int k = 0; k < N; k++) begin
      fetch(k, 32'h6, 0);
      fetch(k, 32'h400, 0);
    end

    prog_write(32'h400, 32'hDEAD_BEEF);
    fetch(0, 32'h0, 0);
    fetch(1, 32'h0, 0);

    collide(0, 32'h4, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
    collide(1, 32'h20, 32'h1234_5678, 32'h8765_4321);
    collide(2, 32'h3FC, 32'hCAFE_0001, 32'hCAFE_0002);

    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 20; i++) begin
        case ($urandom_range(0, 9))
          7:       a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
          8, 9:    a = $urandom | 32'h0000_0400;
          default: a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        endcase
        fetch(k, a, $urandom_range(0, 3));
      end
    end

    // Asynchronous reset in the middle of a long wait.
    fetch(2, 32'hC, 0);
    req_valid[2] = 1'b1; req_addr[2] = 32'h8;
    tick();
    req_valid[2] = 1'b0;
    tick(); tick(); tick();
    #1 rst = 1'b0;
    #1;
    chk("midrst_valid", 2, 32'(resp_valid[2]), 32'd0);
    chk("midrst_instr", 2, resp_instr[2], 32'd0);
    chk("midrst_addr", 2, resp_addr[2], 32'd0);
    chk("midrst_err", 2, 32'(resp_err[2]), 32'd0);
    for (int k = 0; k < N; k++) chk("midrst_req_ready", k, 32'(req_ready[k]), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) chk("rerelease_req_ready", k, 32'(req_ready[k]), 32'd1);
    fetch(2, 32'h8, 0);
    fetch(0, 32'h4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
